fetch_stage: RTL and testbench

- Instruction-fetch stage of the non-forwarding pipeline.
- Owns the PC register, the request/acknowledge handshake to the instruction SRAM, and the IF/ID pipeline register.
- Consumes the hazard unit's pc_wren / IFID_wren / IFID_clear controls plus the EX/MEM redirect (pcsel, target), and produces IFID_pc / IFID_instr for decode.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_stage_ifid_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_fetch_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  // Instructions are word aligned; the low two target bits are meaningless.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register.
// Order of precedence: clear (bubble) > load (real instruction) > write enable
// without load (bubble) > hold.
module ifid_reg #(
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wren,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        valid
);
  import fetch_pkg::ifid_t;

  localparam ifid_t BUBBLE = '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};

  ifid_t q;

  // IF/ID contents: bubble on clear or idle write, instruction on load, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= BUBBLE;
    end else if (clear) begin
      q <= BUBBLE;
    end else if (load) begin
      q <= '{pc: load_pc, instr: load_instr, valid: 1'b1};
    end else if (wren) begin
      q <= BUBBLE;
    end
  end

  assign pc    = q.pc;
  assign instr = q.instr;
  assign valid = q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, SRAM req/ack handshake and IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds fetch/bubble load counters.
//
// state  | meaning
// S_REQ  | issue imem_req for pc (suppressed while redirect_en is high)
// S_WAIT | request outstanding; waiting for imem_ack
// S_HOLD | instruction acked but stage stalled/cleared; kept in hold buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        pc_wren,
  input  logic        IFID_wren,
  input  logic        IFID_clear,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_pc,
  output logic [31:0] IFID_instr,
  output logic        IFID_valid,
  output logic        fetch_busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);
  import fetch_pkg::*;

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  addr_q, addr_n;
  logic [31:0]  hold_buf, hold_buf_n;
  logic         discard, discard_n;
  logic         advance;
  logic         take;
  logic         deliver;
  logic [31:0]  deliver_instr;
  logic [31:0]  redirect_tgt;

  // A redirect or any stall blocks advancing; clear additionally blocks
  // delivery but the fetched word is kept for later.
  assign advance      = pc_wren & IFID_wren & ~redirect_en;
  assign take         = advance & ~IFID_clear;
  assign redirect_tgt = align_pc(redirect_pc);

  // Request is combinational so the SRAM sees it in the S_REQ cycle itself;
  // gated by reset so nothing is issued while reset is held.
  assign imem_req   = (state == S_REQ) & ~redirect_en & ~i_reset;
  assign imem_addr  = (state == S_REQ) ? pc : addr_q;
  assign fetch_busy = (state == S_WAIT);

  // State, PC, address latch, discard flag and hold buffer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      addr_q   <= RESET_PC;
      hold_buf <= NOP_INSTR;
      discard  <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      addr_q   <= addr_n;
      hold_buf <= hold_buf_n;
      discard  <= discard_n;
    end
  end

  // Next-state logic and IF/ID delivery decision.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    addr_n        = addr_q;
    hold_buf_n    = hold_buf;
    discard_n     = discard;
    deliver       = 1'b0;
    deliver_instr = hold_buf;

    case (state)
      S_REQ: begin
        if (redirect_en) begin
          pc_n = redirect_tgt;
        end else begin
          addr_n  = pc;
          state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_en) begin
          pc_n = redirect_tgt;
          if (imem_ack) begin
            // Wrong-path word arrives with the redirect: drop it now.
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else begin
            discard_n = 1'b1;
          end
        end else if (imem_ack) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else if (take) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            pc_n          = pc + PC_STEP;
            state_n       = S_REQ;
          end else begin
            hold_buf_n = imem_rdata;
            state_n    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_en) begin
          pc_n    = redirect_tgt;
          state_n = S_REQ;
        end else if (take) begin
          deliver = 1'b1;
          pc_n    = pc + PC_STEP;
          state_n = S_REQ;
        end
      end

      default: begin
        state_n = S_REQ;
      end
    endcase
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk        (i_clk),
    .rst        (i_reset),
    .wren       (IFID_wren),
    .clear      (IFID_clear),
    .load       (deliver),
    .load_pc    (pc),
    .load_instr (deliver_instr),
    .pc         (IFID_pc),
    .instr      (IFID_instr),
    .valid      (IFID_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic bubble_load;

  assign bubble_load = IFID_clear | (IFID_wren & ~deliver);

  // Count every IF/ID load, split into real instructions and bubbles.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      perf_fetch_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else begin
      if (deliver)     perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (bubble_load) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: SRAM model with programmable ack
// delay, scoreboard of expected IF/ID instructions, directed control checks.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        pc_wren, IFID_wren, IFID_clear, redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] IFID_pc, IFID_instr;
  logic        IFID_valid, fetch_busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

  fetch_stage dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .pc_wren     (pc_wren),
    .IFID_wren   (IFID_wren),
    .IFID_clear  (IFID_clear),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .IFID_pc     (IFID_pc),
    .IFID_instr  (IFID_instr),
    .IFID_valid  (IFID_valid),
    .fetch_busy  (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input logic [31:0] addr);
    sb.push_back('{pc: addr, instr: addr ^ KEY});
  endtask

  // SRAM model: captures a request at the falling edge, acks sram_delay cycles later.
  int          sram_delay = 1;
  int          wait_left  = 0;
  logic [31:0] pend_addr  = 32'h0;

  always @(negedge i_clk) begin
    imem_ack = 1'b0;
    if (wait_left > 0) begin
      wait_left--;
      if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = pend_addr ^ KEY;
      end
    end
    if (imem_req) begin
      pend_addr = imem_addr;
      wait_left = sram_delay;
    end
  end

  // Monitor: every IF/ID load is a valid pop from the scoreboard or a bubble.
  int   mon_valid_loads  = 0;
  int   mon_bubble_loads = 0;
  logic mon_ld, mon_rst;
  exp_t mon_e;

  always begin
    @(posedge i_clk);
    mon_rst = i_reset;
    mon_ld  = IFID_wren | IFID_clear;
    #3;
    if (mon_rst) begin
      mon_valid_loads  = 0;
      mon_bubble_loads = 0;
    end else if (mon_ld) begin
      if (IFID_valid) begin
        mon_valid_loads++;
        if (sb.size() == 0) begin
          check("ifid_unexpected_pc", IFID_pc, 32'hDEAD_BEEF);
        end else begin
          mon_e = sb.pop_front();
          check("ifid_pc", IFID_pc, mon_e.pc);
          check("ifid_instr", IFID_instr, mon_e.instr);
        end
      end else begin
        mon_bubble_loads++;
      end
    end
  end

  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; pc_wren = 1'b1; IFID_wren = 1'b1; IFID_clear = 1'b0;
    redirect_en = 1'b0; redirect_pc = 32'h0;
    nxt(); nxt();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_ifid_pc", IFID_pc, 32'h0);
    check("rst_ifid_instr", IFID_instr, 32'h13);
    check("rst_ifid_valid", IFID_valid, 0);
    check("rst_busy", fetch_busy, 0);

    // Streaming fetch, ack delay 1
    i_reset = 1'b0;
    push_exp(32'h0); push_exp(32'h4);
    #1;
    check("a_req", imem_req, 1);
    check("a_addr", imem_addr, 32'h0);
    nxt(); #1;
    check("b_busy", fetch_busy, 1);
    check("b_req", imem_req, 0);
    nxt(); #1;
    check("c_valid", IFID_valid, 1);
    check("c_addr", imem_addr, 32'h4);
    nxt(); #1;
    check("d_valid", IFID_valid, 0);
    check("d_bubble_pc", IFID_pc, 32'h0);

    // Stall around the ack for pc 8
    nxt();
    pc_wren = 1'b0; IFID_wren = 1'b0; #1;
    check("e_valid", IFID_valid, 1);
    check("e_req", imem_req, 1);
    check("e_addr", imem_addr, 32'h8);
    nxt(); #1;
    check("f_busy", fetch_busy, 1);
    nxt(); #1;
    check("g_busy", fetch_busy, 0);
    check("g_req", imem_req, 0);
    check("g_hold_pc", IFID_pc, 32'h4);
    check("g_hold_valid", IFID_valid, 1);
    nxt();
    pc_wren = 1'b1; IFID_wren = 1'b1; push_exp(32'h8); #1;
    check("h_hold_pc", IFID_pc, 32'h4);
    nxt(); #1;
    check("i_req", imem_req, 1);
    check("i_addr", imem_addr, 32'hC);
    sram_delay = 3;

    // Redirect while waiting; late ack must be dropped
    nxt();
    redirect_en = 1'b1; redirect_pc = 32'h100; #1;
    check("j_addr_held", imem_addr, 32'hC);
    check("j_valid", IFID_valid, 0);
    nxt();
    redirect_en = 1'b0; sram_delay = 1; #1;
    check("k_busy", fetch_busy, 1);
    check("k_valid", IFID_valid, 0);
    check("k_instr", IFID_instr, 32'h13);
    nxt(); #1;
    check("l_valid", IFID_valid, 0);
    push_exp(32'h100);
    nxt(); #1;
    check("m_req", imem_req, 1);
    check("m_addr", imem_addr, 32'h100);
    check("m_valid", IFID_valid, 0);
    nxt(); #1;
    check("n_valid", IFID_valid, 0);
    nxt(); #1;
    check("o_valid", IFID_valid, 1);
    check("o_addr", imem_addr, 32'h104);

    // Clear + redirect in the ack cycle
    nxt();
    IFID_clear = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h200; #1;
    nxt();
    IFID_clear = 1'b0; redirect_en = 1'b0; push_exp(32'h200); #1;
    check("q_pc", IFID_pc, 32'h0);
    check("q_instr", IFID_instr, 32'h13);
    check("q_valid", IFID_valid, 0);
    check("q_req", imem_req, 1);
    check("q_addr", imem_addr, 32'h200);
    nxt(); #1;
    nxt(); #1;
    check("s_valid", IFID_valid, 1);
    check("s_addr", imem_addr, 32'h204);

    // Clear alone in the ack cycle: word is buffered, delivered afterwards
    nxt();
    IFID_clear = 1'b1; #1;
    nxt();
    IFID_clear = 1'b0; push_exp(32'h204); #1;
    check("u_valid", IFID_valid, 0);
    check("u_busy", fetch_busy, 0);
    check("u_req", imem_req, 0);
    nxt(); #1;
    check("v_addr", imem_addr, 32'h208);
    sram_delay = 2;

    // Reset in S_WAIT; stale ack arrives after deassert
    nxt();
    i_reset = 1'b1; #1;
    check("w_valid", IFID_valid, 0);
    check("w_instr", IFID_instr, 32'h13);
    check("w_addr", imem_addr, 32'h0);
    check("w_busy", fetch_busy, 0);
    nxt();
    i_reset = 1'b0; push_exp(32'h0); #1;
    check("x_req", imem_req, 1);
    check("x_addr", imem_addr, 32'h0);
    nxt(); #1;
    check("y_busy", fetch_busy, 1);
    check("y_valid", IFID_valid, 0);
    nxt(); #1;
    check("z_valid", IFID_valid, 0);

    // PC wrap; misaligned redirect target
    nxt();
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFF; sram_delay = 1; #1;
    check("aa_valid", IFID_valid, 1);
    check("aa_req", imem_req, 0);
    nxt();
    redirect_en = 1'b0; push_exp(32'hFFFF_FFFC); push_exp(32'h0); #1;
    check("ab_addr", imem_addr, 32'hFFFF_FFFC);
    nxt(); #1;
    nxt(); #1;
    check("ad_valid", IFID_valid, 1);
    check("ad_addr_wrap", imem_addr, 32'h0);
    nxt(); nxt(); nxt();
    #5;
    check("sb_empty", sb.size(), 0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, mon_valid_loads);
    check("perf_bubble", perf_bubble_cnt, mon_bubble_loads);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
